// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and arrow-key payload type for the keyboard input path.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned CNT_W      = 4;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } arrow_t;

    // One-hot arrow mask for a scan code; all zero for non-arrow codes.
    function automatic arrow_t key_mask(input logic [7:0] code);
        arrow_t m;
        m       = '0;
        m.up    = (code == KEY_UP);
        m.down  = (code == KEY_DOWN);
        m.left  = (code == KEY_LEFT);
        m.right = (code == KEY_RIGHT);
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge sampling,
// start/stop/odd-parity checks and a mid-frame idle timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              clk_s1, clk_s2, clk_prev;
    logic              dat_s1, dat_s2;
    logic [9:0]        shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic              fall_c;
    logic [10:0]       frame_c;
    logic              frame_ok_c;

    // Earlier bits sit in shreg; the bit being sampled now completes the frame.
    assign fall_c     = clk_prev & ~clk_s2;
    assign frame_c    = {dat_s2, shreg};
    assign frame_ok_c = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            byte_o   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            if (fall_c) begin
                shreg    <= frame_c[10:1];
                idle_cnt <= '0;
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    byte_o  <= frame_c[8:1];
                    valid_o <= frame_ok_c;
                    err_o   <= ~frame_ok_c;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else begin
                // Saturating idle count; abandons a stalled partial frame.
                if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end else if (bit_cnt != '0) begin
                    bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard arrow-key decoder: tracks E0/F0 prefixes and holds one level per arrow key.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic up,
    output logic down,
    output logic left,
    output logic right
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;
    arrow_t     keys;
    arrow_t     mask_c;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .byte_o  (rx_byte),
        .valid_o (rx_valid),
        .err_o   (rx_err)
    );

    assign mask_c = key_mask(rx_byte);

    // Break releases regardless of E0; make only counts with E0 (plain codes are keypad).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            keys <= '0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                if (brk) begin
                    keys <= arrow_t'(keys & ~mask_c);
                end else if (ext) begin
                    keys <= arrow_t'(keys | mask_c);
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end else if (rx_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end
    end

    assign up    = keys.up;
    assign down  = keys.down;
    assign left  = keys.left;
    assign right = keys.right;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: directed frames push expected arrow states,
// a monitor pops and checks on every output change, including make/break latency.
module tb_ps2_keyboard;

    localparam int unsigned TMO = 300;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic up, down, left, right;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_stop_cyc = 0;
    bit mon_en = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] model_state = 4'b0000;
    logic [3:0] prev_out = 4'b0000;

    ps2_keyboard #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .up      (up),
        .down    (down),
        .left    (left),
        .right   (right)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of {up,down,left,right} must match the next queued state.
    always @(negedge clk) begin
        logic [3:0] cur;
        logic [3:0] want;
        cur = {up, down, left, right};
        if (mon_en && cur != prev_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got=%b none_expected t=%0t", cur, $time);
            end else begin
                want = exp_q.pop_front();
                if (cur !== want) begin
                    errors++;
                    $display("FAIL state got=%b want=%b t=%0t", cur, want, $time);
                end
                checks++;
                if (cyc - last_stop_cyc != 4) begin
                    errors++;
                    $display("FAIL latency got=%0d want=4 cycles", cyc - last_stop_cyc);
                end
            end
        end
        prev_out = cur;
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) last_stop_cyc = cyc;
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    // Send one frame; exp is the hand-computed {up,down,left,right} after it.
    task automatic vec(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                       input logic [3:0] exp);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        bits[9]   = (~^data) ^ bad_par;
        bits[10]  = ~bad_stop;
        if (exp != model_state) exp_q.push_back(exp);
        model_state = exp;
        send_bits(bits, 11);
        repeat (40) @(negedge clk);
    endtask

    task automatic check_state(input string name);
        logic [3:0] cur;
        cur = {up, down, left, right};
        checks++;
        if (cur !== model_state) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, cur, model_state);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] part;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        #1 rst = 1'b0;
        #100;
        check_state("reset");
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (50) @(negedge clk);
        check_state("idle_after_reset");

        // Up make/break, plain and extended break
        vec(8'hE0, 0, 0, 4'b0000);
        vec(8'h75, 0, 0, 4'b1000);
        vec(8'hF0, 0, 0, 4'b1000);
        vec(8'h75, 0, 0, 4'b0000);
        vec(8'hE0, 0, 0, 4'b0000);
        vec(8'h75, 0, 0, 4'b1000);
        vec(8'hE0, 0, 0, 4'b1000);
        vec(8'hF0, 0, 0, 4'b1000);
        vec(8'h75, 0, 0, 4'b0000);
        check_state("up_seq");

        // Down, left, right
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h72, 0, 0, 4'b0100);
        vec(8'hF0, 0, 0, 4'b0100); vec(8'h72, 0, 0, 4'b0000);
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h6B, 0, 0, 4'b0010);
        vec(8'hF0, 0, 0, 4'b0010); vec(8'h6B, 0, 0, 4'b0000);
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h74, 0, 0, 4'b0001);
        vec(8'hF0, 0, 0, 4'b0001); vec(8'h74, 0, 0, 4'b0000);
        check_state("arrows_seq");

        // Simultaneous keys with typematic repeat
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h75, 0, 0, 4'b1000);
        vec(8'hE0, 0, 0, 4'b1000); vec(8'h75, 0, 0, 4'b1000);
        vec(8'hE0, 0, 0, 4'b1000); vec(8'h6B, 0, 0, 4'b1010);
        vec(8'hF0, 0, 0, 4'b1010); vec(8'h75, 0, 0, 4'b0010);
        check_state("simultaneous");
        vec(8'hE0, 0, 0, 4'b0010); vec(8'hF0, 0, 0, 4'b0010);
        vec(8'h6B, 0, 0, 4'b0000);

        // Error cases: bad parity, bad stop, error clearing ext, keypad code
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h75, 1, 0, 4'b0000);
        vec(8'h75, 0, 0, 4'b0000);
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h75, 0, 1, 4'b0000);
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h72, 1, 0, 4'b0000);
        vec(8'h72, 0, 0, 4'b0000);
        vec(8'h75, 0, 0, 4'b0000);
        check_state("errors");

        // Timeout: 5 bits of a partial frame, then idle past the limit
        part = 11'b111_1110_0000;
        send_bits(part, 5);
        repeat (TMO + 100) @(negedge clk);
        vec(8'hE0, 0, 0, 4'b0000); vec(8'h75, 0, 0, 4'b1000);
        check_state("after_timeout");
        vec(8'hF0, 0, 0, 4'b1000); vec(8'h75, 0, 0, 4'b0000);

        repeat (50) @(negedge clk);
        check_state("final");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
